// File: rtl/comp_resp_checker.sv
// comp_resp_checker: response checker for a COMP (a/b -> gt/lt/eq) instance.
// Every accepted vector travels through a LAT-deep expectation pipeline.
// When the vector reaches the end of that pipeline, the DUT outputs are
// compared against the expected code. The checker reports pass/fail, the
// check and error counts, and the first failing vector.
// Optional macro COMP_CHK_SIGNED_EN: the expected code uses a two's-complement
// signed comparison. When the macro is undefined the comparison is unsigned.
module comp_resp_checker #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16,
  parameter int LAT       = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [CNTWIDTH-1:0]  num_vec,
  input  logic                 vec_valid,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 gt,
  input  logic                 lt,
  input  logic                 eq,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNTWIDTH-1:0]  chk_cnt,
  output logic [CNTWIDTH-1:0]  err_cnt,
  output logic [DATAWIDTH-1:0] fail_a,
  output logic [DATAWIDTH-1:0] fail_b,
  output logic [2:0]           fail_code
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state;
  logic [CNTWIDTH-1:0]    num_lat;
  logic [CNTWIDTH-1:0]    acc_cnt;
  logic                   accept;
  logic                   chk_vld;
  logic [2:0]             chk_exp;
  logic [DATAWIDTH-1:0]   chk_a;
  logic [DATAWIDTH-1:0]   chk_b;
  logic [2:0]             obs;

  // Expected {gt,lt,eq} for a pair of operands.
  function automatic logic [2:0] exp_code(input logic [DATAWIDTH-1:0] x,
                                          input logic [DATAWIDTH-1:0] y);
`ifdef COMP_CHK_SIGNED_EN
    logic signed [DATAWIDTH-1:0] xs;
    logic signed [DATAWIDTH-1:0] ys;
    xs = x;
    ys = y;
    if (xs > ys)      return 3'b100;
    else if (xs < ys) return 3'b010;
    else              return 3'b001;
`else
    if (x > y)        return 3'b100;
    else if (x < y)   return 3'b010;
    else              return 3'b001;
`endif
  endfunction

  // Saturating increment for the error counter.
  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
    if (v == {CNTWIDTH{1'b1}}) return v;
    else                       return v + CNTWIDTH'(1);
  endfunction

  assign obs    = {gt, lt, eq};
  assign accept = (state == S_RUN) && vec_valid && (acc_cnt < num_lat);

  generate
    if (LAT == 0) begin : g_lat0
      // No latency: check the current inputs on the accepting edge.
      assign chk_vld = accept;
      assign chk_exp = exp_code(a, b);
      assign chk_a   = a;
      assign chk_b   = b;
    end else begin : g_pipe
      logic                 vld_p [LAT];
      logic [2:0]           exp_p [LAT];
      logic [DATAWIDTH-1:0] a_p   [LAT];
      logic [DATAWIDTH-1:0] b_p   [LAT];

      // Valid bits: an accepted vector or a bubble enters stage 0 each cycle.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= accept;
          for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      // Payload follows its valid bit. Bubbles carry don't-care data.
      always_ff @(posedge Clk) begin
        exp_p[0] <= exp_code(a, b);
        a_p[0]   <= a;
        b_p[0]   <= b;
        for (int i = 1; i < LAT; i++) begin
          exp_p[i] <= exp_p[i-1];
          a_p[i]   <= a_p[i-1];
          b_p[i]   <= b_p[i-1];
        end
      end

      // ---- last stage: vector meets the DUT result ----
      assign chk_vld = vld_p[LAT-1];
      assign chk_exp = exp_p[LAT-1];
      assign chk_a   = a_p[LAT-1];
      assign chk_b   = b_p[LAT-1];
    end
  endgenerate

  // Run control, counters and first-failure capture.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_code <= '0;
      num_lat   <= '0;
      acc_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_code <= '0;
            acc_cnt   <= '0;
            num_lat   <= num_vec;
            if (num_vec == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept) acc_cnt <= acc_cnt + CNTWIDTH'(1);
          if (chk_vld) begin
            chk_cnt <= chk_cnt + CNTWIDTH'(1);
            if (obs != chk_exp) begin
              err_cnt <= sat_inc(err_cnt);
              if (err_cnt == '0) begin
                fail_a    <= chk_a;
                fail_b    <= chk_b;
                fail_code <= obs;
              end
            end
          end
          // Leave one cycle after the final check has been counted.
          if (chk_cnt == num_lat) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_resp_checker.sv
// Testbench for comp_resp_checker (default LAT=1) driven by a registered
// comparator model with selectable faults.
module tb_comp_resp_checker;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          vec_valid;
  logic [DW-1:0] a, b;
  logic          gt, lt, eq;
  logic          busy, done, pass;
  logic [CW-1:0] chk_cnt, err_cnt;
  logic [DW-1:0] fail_a, fail_b;
  logic [2:0]    fail_code;

  int n_checks = 0;
  int n_errors = 0;
  int fault    = 0;

  comp_resp_checker dut (
    .Clk(Clk), .Rst(Rst), .start(start), .num_vec(num_vec),
    .vec_valid(vec_valid), .a(a), .b(b), .gt(gt), .lt(lt), .eq(eq),
    .busy(busy), .done(done), .pass(pass), .chk_cnt(chk_cnt),
    .err_cnt(err_cnt), .fail_a(fail_a), .fail_b(fail_b), .fail_code(fail_code)
  );

  always #5 Clk = ~Clk;

  // Registered COMP model. fault: 0 ideal, 1 gt stuck at 0, 2 always 100, 3 always 011.
  function automatic logic [2:0] model_code(input logic [DW-1:0] x, input logic [DW-1:0] y);
`ifdef COMP_CHK_SIGNED_EN
    logic signed [DW-1:0] xs;
    logic signed [DW-1:0] ys;
    xs = x;
    ys = y;
    return {xs > ys, xs < ys, xs == ys};
`else
    return {x > y, x < y, x == y};
`endif
  endfunction

  always @(posedge Clk) begin
    case (fault)
      1:       {gt, lt, eq} <= model_code(a, b) & 3'b011;
      2:       {gt, lt, eq} <= 3'b100;
      3:       {gt, lt, eq} <= 3'b011;
      default: {gt, lt, eq} <= model_code(a, b);
    endcase
  end

  typedef struct packed {
    logic [15:0]      n;
    logic [3:0][7:0]  va;
    logic [3:0][7:0]  vb;
    logic [1:0]       flt;
    logic [15:0]      e_err;
    logic             e_pass;
    logic [7:0]       e_fa;
    logic [7:0]       e_fb;
    logic [2:0]       e_fc;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int n,
                              input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1,
                              input logic [7:0] a2, input logic [7:0] b2,
                              input logic [7:0] a3, input logic [7:0] b3,
                              input int flt, input int e_err, input logic e_pass,
                              input logic [7:0] e_fa, input logic [7:0] e_fb,
                              input logic [2:0] e_fc);
    vec_t v;
    v.n = 16'(n);
    v.va[0] = a0; v.vb[0] = b0;
    v.va[1] = a1; v.vb[1] = b1;
    v.va[2] = a2; v.vb[2] = b2;
    v.va[3] = a3; v.vb[3] = b3;
    v.flt = 2'(flt);
    v.e_err = 16'(e_err);
    v.e_pass = e_pass;
    v.e_fa = e_fa;
    v.e_fb = e_fb;
    v.e_fc = e_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic do_run(input vec_t v, input int idx);
    fault = int'(v.flt);
    start = 1'b1;
    num_vec = v.n;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      vec_valid = 1'b1;
      a = v.va[i];
      b = v.vb[i];
      tick();
    end
    vec_valid = 1'b0;
    wait_done();
    check($sformatf("t%0d_chk_cnt", idx), {16'd0, chk_cnt}, {16'd0, v.n});
    check($sformatf("t%0d_err_cnt", idx), {16'd0, err_cnt}, {16'd0, v.e_err});
    check($sformatf("t%0d_pass", idx), {31'd0, pass}, {31'd0, v.e_pass});
    check($sformatf("t%0d_busy", idx), {31'd0, busy}, 32'd0);
    check($sformatf("t%0d_fail_a", idx), {24'd0, fail_a}, {24'd0, v.e_fa});
    check($sformatf("t%0d_fail_b", idx), {24'd0, fail_b}, {24'd0, v.e_fb});
    check($sformatf("t%0d_fail_code", idx), {29'd0, fail_code}, {29'd0, v.e_fc});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_chk_cnt"}, {16'd0, chk_cnt}, 32'd0);
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
    check({tag, "_fail_a"}, {24'd0, fail_a}, 32'd0);
    check({tag, "_fail_b"}, {24'd0, fail_b}, 32'd0);
    check({tag, "_fail_code"}, {29'd0, fail_code}, 32'd0);
  endtask

  initial begin
    tbl[0] = mk(3, 8'd0, 8'd0, 8'd20, 8'd15, 8'd6, 8'd10, 8'd0, 8'd0,
                0, 0, 1'b1, 8'd0, 8'd0, 3'b000);
    tbl[1] = mk(3, 8'd0, 8'd0, 8'd20, 8'd15, 8'd6, 8'd10, 8'd0, 8'd0,
                1, 1, 1'b0, 8'd20, 8'd15, 3'b000);
`ifdef COMP_CHK_SIGNED_EN
    tbl[2] = mk(2, 8'h80, 8'h01, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0,
                2, 2, 1'b0, 8'h80, 8'h01, 3'b100);
`else
    tbl[2] = mk(2, 8'h80, 8'h01, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0,
                2, 1, 1'b0, 8'd3, 8'd3, 3'b100);
`endif
    tbl[3] = mk(1, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                3, 1, 1'b0, 8'd5, 8'd9, 3'b011);
    tbl[4] = mk(4, 8'd255, 8'd0, 8'd0, 8'd255, 8'd128, 8'd127, 8'd127, 8'd128,
                0, 0, 1'b1, 8'd0, 8'd0, 3'b000);

    Rst = 1'b1;
    start = 1'b0;
    num_vec = '0;
    vec_valid = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check_all_zero("reset");
    Rst = 1'b0;
    tick();

    // Latency of done relative to the last check, ideal model.
    fault = 0;
    start = 1'b1; num_vec = 16'd3; tick();
    start = 1'b0;
    check("seq_busy_after_start", {31'd0, busy}, 32'd1);
    vec_valid = 1'b1; a = 8'd0;  b = 8'd0;  tick();
    a = 8'd20; b = 8'd15; tick();
    a = 8'd6;  b = 8'd10; tick();
    vec_valid = 1'b0;
    check("seq_chk_cnt_before_last", {16'd0, chk_cnt}, 32'd2);
    tick();
    check("seq_chk_cnt_last", {16'd0, chk_cnt}, 32'd3);
    check("seq_done_not_yet", {31'd0, done}, 32'd0);
    tick();
    check("seq_done_rise", {31'd0, done}, 32'd1);
    check("seq_pass", {31'd0, pass}, 32'd1);

    // Table-driven runs.
    for (int i = 0; i < 5; i++) do_run(tbl[i], i);

    // Surplus pulses and a gap: only two vectors may be accepted.
    fault = 0;
    start = 1'b1; num_vec = 16'd2; tick();
    start = 1'b0;
    vec_valid = 1'b1; a = 8'd1; b = 8'd2; tick();
    vec_valid = 1'b0; tick(); tick(); tick();
    check("gap_chk_cnt", {16'd0, chk_cnt}, 32'd1);
    vec_valid = 1'b1; a = 8'd3; b = 8'd3; tick();
    a = 8'd9; b = 8'd1; tick();
    a = 8'd4; b = 8'd4; tick();
    vec_valid = 1'b0;
    wait_done();
    tick(); tick();
    check("gap_chk_cnt_final", {16'd0, chk_cnt}, 32'd2);
    check("gap_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("gap_pass", {31'd0, pass}, 32'd1);

    // Zero-length run.
    start = 1'b1; num_vec = 16'd0; tick();
    start = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_pass", {31'd0, pass}, 32'd1);
    check("zero_chk_cnt", {16'd0, chk_cnt}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a run after one failing check.
    fault = 1;
    start = 1'b1; num_vec = 16'd3; tick();
    start = 1'b0;
    vec_valid = 1'b1; a = 8'd20; b = 8'd15; tick();
    vec_valid = 1'b0; tick();
    check("mid_err_before_rst", {16'd0, err_cnt}, 32'd1);
    check("mid_fail_a_before_rst", {24'd0, fail_a}, 32'd20);
    #2 Rst = 1'b1;
    #1 check_all_zero("async_rst");
    #1 Rst = 1'b0;
    tick();
    fault = 0;
    // vec_valid while idle must be ignored.
    vec_valid = 1'b1; a = 8'd1; b = 8'd9; tick(); tick();
    vec_valid = 1'b0;
    check("idle_chk_cnt", {16'd0, chk_cnt}, 32'd0);
    start = 1'b1; num_vec = 16'd1; tick();
    start = 1'b0;
    vec_valid = 1'b1; a = 8'd7; b = 8'd7; tick();
    vec_valid = 1'b0;
    wait_done();
    check("post_rst_pass", {31'd0, pass}, 32'd1);
    check("post_rst_chk_cnt", {16'd0, chk_cnt}, 32'd1);
    check("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Restart from DONE clears done and pass.
    start = 1'b1; num_vec = 16'd1; tick();
    start = 1'b0;
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_pass_clr", {31'd0, pass}, 32'd0);
    check("restart_chk_clr", {16'd0, chk_cnt}, 32'd0);
    vec_valid = 1'b1; a = 8'd2; b = 8'd1; tick();
    vec_valid = 1'b0;
    wait_done();
    check("restart_pass", {31'd0, pass}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comp_resp_checker.md
Name: comp_resp_checker

Overview:
- Synthesizable response checker that sits on the output side of a COMP datapath instance; it is the consumer end of the a/b -> gt/lt/eq interface.
- Each accepted vector (a,b) is tracked through a LAT-deep expectation pipeline, and the DUT's gt/lt/eq are compared against the expected result when that vector emerges.
- It reports pass/fail, check and error counts, and the first failing vector, for on-chip self-test of comparator instances.

Parameters:
- DATAWIDTH, 8, width of operands a and b.
- CNTWIDTH, 16, width of num_vec and all counters.
- LAT, 1, DUT result latency in clock cycles; legal range 0..3.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse that begins a run
- num_vec  in  CNTWIDTH  number of vectors in the run; latched on start
- vec_valid  in  1  a/b are being presented to the DUT this cycle
- a  in  DATAWIDTH  operand A, as driven to the DUT
- b  in  DATAWIDTH  operand B, as driven to the DUT
- gt  in  1  DUT output
- lt  in  1  DUT output
- eq  in  1  DUT output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_cnt==0
- chk_cnt  out  CNTWIDTH  vectors checked so far
- err_cnt  out  CNTWIDTH  mismatches so far; saturates at all-ones
- fail_a  out  DATAWIDTH  a of the first failing vector
- fail_b  out  DATAWIDTH  b of the first failing vector
- fail_code  out  3  observed {gt,lt,eq} at the first failure

Behaviour:
- Reset (async, Rst=1):
  - State goes to IDLE.
  - All outputs are 0 and all pipeline valid bits are cleared.
- States:
  - IDLE: waits for start.
  - RUN: accepts and checks vectors.
  - DONE: holds results.
- Transitions:
  - IDLE, start=1, num_vec==0 -> DONE with pass=1.
  - IDLE, start=1, num_vec!=0 -> RUN. On entry: counters, the internal accept count and the fail_* outputs clear; num_vec is latched.
  - RUN -> DONE on the cycle after chk_cnt reaches the latched num_vec.
  - DONE, start=1 -> restart, following the same rules as IDLE.
  - start in RUN is ignored.
- Acceptance:
  - In RUN, vec_valid=1 accepts a vector only while the accept count is below the latched num_vec.
  - Surplus vec_valid pulses are ignored.
  - vec_valid outside RUN is ignored.
- Expectation: the expected code {gt,lt,eq} is 100 for a>b, 010 for a<b and 001 for a==b. The comparison is unsigned unless the optional feature is enabled.
- Pipeline:
  - Expected code, a, b and a valid bit shift through LAT stages. Stage 0 captures on an accepted vector; a bubble enters otherwise.
  - Compare occurs when the last stage is valid: observed {gt,lt,eq} vs expected, exact 3-bit match. Non-one-hot DUT outputs therefore always fail.
  - LAT=0: the compare is combinational against the current inputs and registers on the same edge that accepts the vector.
- Per check:
  - chk_cnt increments by 1.
  - On mismatch, err_cnt increments, saturating at all-ones.
  - On the first mismatch of the run only, fail_a, fail_b and fail_code are captured.
- Gaps: vec_valid may deassert mid-run. Bubbles are never checked.
- pass is registered, valid only while done=1, and 0 otherwise.
- Reset mid-RUN: immediate return to IDLE. In-flight pipeline entries are discarded and no partial results are kept.

Optional Feature:
- COMP_CHK_SIGNED_EN defined: expected code uses two's-complement signed comparison of a and b.
- Not defined: unsigned comparison. No other behaviour differs.

Test Plan:
- Defaults (LAT=1), ideal registered-COMP model. Start with num_vec=3, then vectors (0,0), (20,15), (6,10). Expected:
  - Checks see codes 001, 100, 010.
  - done rises 1 cycle after the third check; chk_cnt=3, err_cnt=0, pass=1.
- Same run with the model's gt stuck at 0. Expected: err_cnt=1, pass=0, fail_a=20, fail_b=15, fail_code=000.
- num_vec=2 with 4 vec_valid pulses and a 3-cycle gap between pulses 1 and 2. Expected: only 2 vectors accepted, chk_cnt=2, done asserts, bubbles are not counted.
- start with num_vec=0. Expected: DONE and pass=1 on the next cycle, chk_cnt=0.
- Rst pulse asynchronously mid-RUN after 1 of 3 vectors. Expected: all outputs read 0 immediately; a following start with num_vec=1 and vector (7,7) gives pass=1.
- With COMP_CHK_SIGNED_EN defined and vector (8'h80, 8'h01): the model must output 010 to pass. A model returning 100 gives err_cnt=1 and fail_code=100.
